// File: rtl/dma_burst_controller.sv
// DMA sequencer moving word blocks between the system bus and scratchpad port B.
// Configured and started through a custom instruction; transfers run as bursts.
module dma_burst_controller #(
   parameter logic [7:0] customId = 8'd15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  ciN,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   output logic        done,
   output logic [31:0] result,
   output logic [8:0]  memAddress,
   output logic        memWriteEnable,
   output logic [31:0] memWriteData,
   input  logic [31:0] memReadData,
   output logic        requestTransaction,
   input  logic        transactionGranted,
   output logic        beginTransactionOut,
   output logic [31:0] addressDataOut,
   output logic [7:0]  burstSizeOut,
   output logic        readNotWriteOut,
   output logic        dataValidOut,
   output logic        endTransactionOut,
   input  logic        busyIn,
   input  logic        dataValidIn,
   input  logic [31:0] addressDataIn,
   input  logic        endTransactionIn,
   input  logic        busErrorIn
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_REQ,
      S_BEGIN,
      S_RDATA,
      S_WPREF,
      S_WDATA,
      S_WEND,
      S_NEXT,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [8:0]  mem_addr_q, mem_addr_d;
   logic [9:0]  block_q, block_d;
   logic [7:0]  burst_q, burst_d;
   logic        error_q, error_d;
   logic        rnw_q, rnw_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [8:0]  beats_q, beats_d;
   logic [8:0]  beat_q, beat_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_end_q, err_end_d;

   logic        ci_hit;
   logic        ci_we;
   logic [2:0]  ci_sel;
   logic        busy;
   logic        start_ok;
   logic        consume;
   logic [9:0]  remain;
   logic [8:0]  burst_len;
   logic [8:0]  next_beats;
   logic [8:0]  mem_ptr;
   logic [31:0] bus_ptr;
   logic        unused_bits;

   assign ci_hit      = start & (ciN == customId);
   assign ci_sel      = valueA[12:10];
   assign ci_we       = valueA[9];
   assign unused_bits = ^{valueA[31:13], valueA[8:0]};
   assign done        = ci_hit;
   assign busy        = (state_q != S_IDLE);

   assign start_ok = ci_hit & ci_we & (ci_sel == 3'd5) & ~busy
                   & (valueB[0] | valueB[1]);

   assign remain     = block_q - cnt_q;
   assign burst_len  = {1'b0, burst_q} + 9'd1;
   assign next_beats = (remain < {1'b0, burst_len}) ? remain[8:0] : burst_len;

   // SRAM side wraps at 512 words, so only the low counter bits matter
   assign mem_ptr = mem_addr_q + cnt_q[8:0];
   assign bus_ptr = bus_addr_q + {20'd0, cnt_q, 2'b00};
   assign consume = (state_q == S_WDATA) & ~busyIn;

   always_comb begin
      result = '0;
      if (ci_hit) begin
         case (ci_sel)
            3'd1:    result = bus_addr_q;
            3'd2:    result = {23'd0, mem_addr_q};
            3'd3:    result = {22'd0, block_q};
            3'd4:    result = {24'd0, burst_q};
            3'd5:    result = {30'd0, error_q, busy};
            default: result = '0;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      bus_addr_d = bus_addr_q;
      mem_addr_d = mem_addr_q;
      block_d    = block_q;
      burst_d    = burst_q;
      error_d    = error_q;
      rnw_d      = rnw_q;
      cnt_d      = cnt_q;
      beats_d    = beats_q;
      beat_d     = beat_q;
      wdata_d    = wdata_q;
      err_end_d  = err_end_q;

      memAddress          = '0;
      memWriteEnable      = 1'b0;
      memWriteData        = '0;
      requestTransaction  = 1'b0;
      beginTransactionOut = 1'b0;
      addressDataOut      = '0;
      burstSizeOut        = '0;
      readNotWriteOut     = 1'b0;
      dataValidOut        = 1'b0;
      endTransactionOut   = 1'b0;

      if (ci_hit && ci_we && !busy) begin
         case (ci_sel)
            3'd1:    bus_addr_d = {valueB[31:2], 2'b00};
            3'd2:    mem_addr_d = valueB[8:0];
            3'd3:    block_d    = valueB[9:0];
            3'd4:    burst_d    = valueB[7:0];
            default: ;
         endcase
      end

      if (start_ok) begin
         error_d = 1'b0;
         rnw_d   = valueB[0];
         cnt_d   = '0;
         if (block_q != 10'd0) state_d = S_REQ;
      end

      case (state_q)
         S_IDLE: ;
         S_REQ: begin
            requestTransaction = 1'b1;
            if (transactionGranted) state_d = S_BEGIN;
         end
         S_BEGIN: begin
            requestTransaction  = 1'b1;
            beginTransactionOut = 1'b1;
            addressDataOut      = bus_ptr;
            burstSizeOut        = next_beats[7:0] - 8'd1;
            readNotWriteOut     = rnw_q;
            beats_d             = next_beats;
            beat_d              = '0;
            if (rnw_q) begin
               state_d = S_RDATA;
            end else begin
               memAddress = mem_ptr;
               state_d    = S_WPREF;
            end
         end
         S_RDATA: begin
            requestTransaction = 1'b1;
            if (dataValidIn && (beat_q < beats_q)) begin
               memWriteEnable = 1'b1;
               memAddress     = mem_ptr;
               memWriteData   = addressDataIn;
               cnt_d          = cnt_q + 10'd1;
               beat_d         = beat_q + 9'd1;
            end
            if (endTransactionIn) state_d = S_NEXT;
         end
         S_WPREF: begin
            requestTransaction = 1'b1;
            wdata_d            = memReadData;
            memAddress         = mem_ptr + 9'd1;
            state_d            = S_WDATA;
         end
         S_WDATA: begin
            requestTransaction = 1'b1;
            dataValidOut       = 1'b1;
            addressDataOut     = wdata_q;
            // read port always runs one word ahead of the word on the bus
            if (consume) begin
               memAddress = mem_ptr + 9'd2;
               wdata_d    = memReadData;
               cnt_d      = cnt_q + 10'd1;
               beat_d     = beat_q + 9'd1;
               if (beat_q == beats_q - 9'd1) state_d = S_WEND;
            end else begin
               memAddress = mem_ptr + 9'd1;
            end
         end
         S_WEND: begin
            requestTransaction = 1'b1;
            endTransactionOut  = 1'b1;
            state_d            = S_NEXT;
         end
         S_NEXT: begin
            state_d = (remain != 10'd0) ? S_REQ : S_IDLE;
         end
         S_ERR: begin
            endTransactionOut = err_end_q;
            state_d           = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (busy && (state_q != S_ERR) && busErrorIn) begin
         state_d   = S_ERR;
         error_d   = 1'b1;
         err_end_d = state_q inside {S_BEGIN, S_RDATA, S_WPREF, S_WDATA, S_WEND};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         bus_addr_q <= '0;
         mem_addr_q <= '0;
         block_q    <= '0;
         burst_q    <= '0;
         error_q    <= 1'b0;
         rnw_q      <= 1'b0;
         cnt_q      <= '0;
         beats_q    <= '0;
         beat_q     <= '0;
         wdata_q    <= '0;
         err_end_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bus_addr_q <= bus_addr_d;
         mem_addr_q <= mem_addr_d;
         block_q    <= block_d;
         burst_q    <= burst_d;
         error_q    <= error_d;
         rnw_q      <= rnw_d;
         cnt_q      <= cnt_d;
         beats_q    <= beats_d;
         beat_q     <= beat_d;
         wdata_q    <= wdata_d;
         err_end_q  <= err_end_d;
      end
   end

endmodule

// File: tb/tb_dma_burst_controller.sv
// Bench for dma_burst_controller: CI driver, bus slave, SRAM model, burst model.
module tb_dma_burst_controller;

   logic        clock, reset, start;
   logic [7:0]  ciN;
   logic [31:0] valueA, valueB;
   logic        done;
   logic [31:0] result;
   logic [8:0]  memAddress;
   logic        memWriteEnable;
   logic [31:0] memWriteData, memReadData;
   logic        requestTransaction, transactionGranted, beginTransactionOut;
   logic [31:0] addressDataOut;
   logic [7:0]  burstSizeOut;
   logic        readNotWriteOut, dataValidOut, endTransactionOut;
   logic        busyIn, dataValidIn;
   logic [31:0] addressDataIn;
   logic        endTransactionIn, busErrorIn;

   int errors = 0;
   int checks = 0;

   logic [31:0] sram [0:511];
   logic [31:0] rd_pend = '0;
   int   grant_delay = 0;
   int   gcnt = 0;
   bit   granted = 0;
   int   rd_left = 0;
   bit   rd_end_pend = 0;
   bit   rd_gaps = 0;
   logic [31:0] rd_src[$];
   int   busy_mode = 0;
   int   wcnt = 0;
   int   stall_n = 0;
   int   err_beat = -1;
   logic [40:0] begins[$];
   logic [31:0] wbeats[$];
   logic [31:0] stalls[$];
   int   ends = 0;

   logic [31:0] cur_bus;
   logic [8:0]  cur_mem;
   int          cur_blk, cur_bst;
   bit          cur_rnw;
   logic [31:0] cur_data[$];

   dma_burst_controller #(.customId(8'd15)) dut (
      .clock(clock), .reset(reset), .start(start), .ciN(ciN),
      .valueA(valueA), .valueB(valueB), .done(done), .result(result),
      .memAddress(memAddress), .memWriteEnable(memWriteEnable),
      .memWriteData(memWriteData), .memReadData(memReadData),
      .requestTransaction(requestTransaction),
      .transactionGranted(transactionGranted),
      .beginTransactionOut(beginTransactionOut),
      .addressDataOut(addressDataOut), .burstSizeOut(burstSizeOut),
      .readNotWriteOut(readNotWriteOut), .dataValidOut(dataValidOut),
      .endTransactionOut(endTransactionOut), .busyIn(busyIn),
      .dataValidIn(dataValidIn), .addressDataIn(addressDataIn),
      .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Bus slave, arbiter and SRAM port B model: drive after posedge, sample at negedge
   initial begin
      memReadData        = '0;
      transactionGranted = 0;
      dataValidIn        = 0;
      endTransactionIn   = 0;
      busyIn             = 0;
      busErrorIn         = 0;
      addressDataIn      = '0;
      forever begin
         @(posedge clock);
         #1;
         memReadData        = rd_pend;
         transactionGranted = 0;
         dataValidIn        = 0;
         endTransactionIn   = 0;
         busyIn             = 0;
         busErrorIn         = 0;
         addressDataIn      = '0;
         if (!reset) begin
            granted     = 0;
            gcnt        = 0;
            rd_left     = 0;
            rd_end_pend = 0;
         end else begin
            if (!requestTransaction) begin
               granted = 0;
               gcnt    = 0;
            end else if (!granted) begin
               if (gcnt >= grant_delay) begin
                  transactionGranted = 1;
                  granted            = 1;
               end else begin
                  gcnt++;
               end
            end
            if (beginTransactionOut && readNotWriteOut) begin
               rd_left     = int'(burstSizeOut) + 1;
               rd_end_pend = 1;
            end else if (rd_left > 0) begin
               if (!rd_gaps || $urandom_range(0, 3) != 0) begin
                  dataValidIn   = 1;
                  addressDataIn = (rd_src.size() > 0) ? rd_src.pop_front() : 32'hDEAD_BEEF;
                  rd_left--;
               end
            end else if (rd_end_pend) begin
               endTransactionIn = 1;
               rd_end_pend      = 0;
            end
            if (dataValidOut) begin
               if (err_beat >= 0 && wcnt == err_beat) begin
                  busErrorIn = 1;
                  err_beat   = -1;
               end else begin
                  case (busy_mode)
                     1: begin
                        busyIn = (wcnt == 1 && stall_n < 3);
                        if (busyIn) stall_n++;
                     end
                     2: busyIn = ($urandom_range(0, 2) == 0);
                     3: busyIn = 1;
                     default: busyIn = 0;
                  endcase
                  if (!busyIn) wcnt++;
               end
            end
         end
         @(negedge clock);
         if (beginTransactionOut)
            begins.push_back({addressDataOut, burstSizeOut, readNotWriteOut});
         if (dataValidOut && !busyIn) wbeats.push_back(addressDataOut);
         if (dataValidOut && busyIn) stalls.push_back(addressDataOut);
         if (endTransactionOut) ends++;
         if (memWriteEnable) sram[memAddress] = memWriteData;
         rd_pend = sram[memAddress];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ci(input logic [7:0] cn, input logic [2:0] sel, input logic we,
                     input logic [31:0] d, output logic dn, output logic [31:0] r);
      @(posedge clock);
      #1;
      start  = 1'b1;
      ciN    = cn;
      valueA = {19'd0, sel, we, 9'd0};
      valueB = d;
      @(negedge clock);
      dn = done;
      r  = result;
      @(posedge clock);
      #1;
      start  = 1'b0;
      ciN    = '0;
      valueA = '0;
      valueB = '0;
   endtask

   task automatic wr(input logic [2:0] sel, input logic [31:0] d);
      logic dn;
      logic [31:0] r;
      ci(8'd15, sel, 1'b1, d, dn, r);
      check("wr_done", 32'(dn), 32'd1);
   endtask

   task automatic rd(input logic [2:0] sel, output logic [31:0] r);
      logic dn;
      ci(8'd15, sel, 1'b0, 32'd0, dn, r);
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] s;
      int n;
      n = 0;
      do begin
         rd(3'd5, s);
         n++;
      end while (s[0] && n < 2000);
      check({tag, "_idle"}, 32'(s[0]), 32'd0);
   endtask

   task automatic fill(input int n);
      cur_data.delete();
      for (int i = 0; i < n; i++) cur_data.push_back($urandom);
   endtask

   task automatic setup(input logic [31:0] bus, input logic [8:0] mem,
                        input int blk, input int bst, input bit rnw);
      cur_bus = {bus[31:2], 2'b00};
      cur_mem = mem;
      cur_blk = blk;
      cur_bst = bst;
      cur_rnw = rnw;
      begins.delete();
      wbeats.delete();
      stalls.delete();
      rd_src.delete();
      ends    = 0;
      wcnt    = 0;
      stall_n = 0;
      for (int i = 0; i < blk; i++) begin
         if (rnw) rd_src.push_back(cur_data[i]);
         else sram[9'(mem + 9'(i))] = cur_data[i];
      end
      wr(3'd1, bus);
      wr(3'd2, {23'd0, mem});
      wr(3'd3, 32'(blk));
      wr(3'd4, 32'(bst));
   endtask

   task automatic verify(input string tag);
      logic [40:0] exp_b[$];
      int dn, b, nb;
      wait_idle(tag);
      dn = 0;
      while (dn < cur_blk) begin
         b = (cur_blk - dn < cur_bst + 1) ? cur_blk - dn : cur_bst + 1;
         exp_b.push_back({cur_bus + 32'(4 * dn), 8'(b - 1), cur_rnw});
         dn += b;
      end
      check({tag, "_nbursts"}, 32'(begins.size()), 32'(exp_b.size()));
      nb = (begins.size() < exp_b.size()) ? begins.size() : exp_b.size();
      for (int i = 0; i < nb; i++) begin
         check({tag, "_baddr"}, begins[i][40:9], exp_b[i][40:9]);
         check({tag, "_bsize"}, 32'(begins[i][8:1]), 32'(exp_b[i][8:1]));
         check({tag, "_brnw"}, 32'(begins[i][0]), 32'(exp_b[i][0]));
      end
      if (cur_rnw) begin
         for (int i = 0; i < cur_blk; i++)
            check({tag, "_sram"}, sram[9'(cur_mem + 9'(i))], cur_data[i]);
         check({tag, "_ends"}, 32'(ends), 32'd0);
      end else begin
         check({tag, "_nbeats"}, 32'(wbeats.size()), 32'(cur_blk));
         nb = (wbeats.size() < cur_blk) ? wbeats.size() : cur_blk;
         for (int i = 0; i < nb; i++)
            check({tag, "_wbeat"}, wbeats[i], cur_data[i]);
         check({tag, "_ends"}, 32'(ends), 32'(exp_b.size()));
      end
   endtask

   function automatic logic [31:0] bus_ctl();
      return 32'({requestTransaction, beginTransactionOut, dataValidOut,
                  endTransactionOut, memWriteEnable, readNotWriteOut});
   endfunction

   initial begin
      logic [31:0] r;
      logic        dn;
      int          seen;
      for (int i = 0; i < 512; i++) sram[i] = '0;
      reset  = 1'b0;
      start  = 1'b0;
      ciN    = '0;
      valueA = '0;
      valueB = '0;

      repeat (3) @(negedge clock);
      check("rst_ctl", bus_ctl(), 32'd0);
      check("rst_addr", addressDataOut, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b1;
      rd(3'd5, r);
      check("rst_status", r, 32'd0);

      // configuration readback
      wr(3'd1, 32'h0000_1003);
      wr(3'd3, 32'd5);
      wr(3'd4, 32'd3);
      ci(8'd15, 3'd1, 1'b0, 32'd0, dn, r);
      check("rd1_done", 32'(dn), 32'd1);
      check("rd1_val", r, 32'h0000_1000);
      ci(8'd15, 3'd3, 1'b0, 32'd0, dn, r);
      check("rd3_val", r, 32'd5);
      rd(3'd4, r);
      check("rd4_val", r, 32'd3);
      wr(3'd2, 32'hFFFF_FFFF);
      rd(3'd2, r);
      check("rd2_val", r, 32'h1FF);
      rd(3'd6, r);
      check("rd6_val", r, 32'd0);
      ci(8'd7, 3'd1, 1'b0, 32'd0, dn, r);
      check("other_ci_done", 32'(dn), 32'd0);
      check("other_ci_res", r, 32'd0);

      // bus to SRAM, wrapping at 511, with busy lockout
      cur_data.delete();
      for (int i = 0; i < 6; i++) cur_data.push_back(32'hA0 + 32'(i));
      grant_delay = 3;
      setup(32'h1000, 9'h1FE, 6, 3, 1'b1);
      wr(3'd5, 32'd3);
      rd(3'd5, r);
      check("b2s_busy", r, 32'd1);
      wr(3'd1, 32'h5555_0000);
      rd(3'd1, r);
      check("lock_reg1", r, 32'h1000);
      wr(3'd5, 32'd2);
      verify("b2s");
      rd(3'd5, r);
      check("b2s_status", r, 32'd0);

      // SRAM to bus with a three-cycle stall on the second beat
      cur_data.delete();
      for (int i = 0; i < 4; i++) cur_data.push_back(32'h11 * 32'(i + 1));
      grant_delay = 1;
      busy_mode   = 1;
      setup(32'h2000, 9'h000, 4, 7, 1'b0);
      wr(3'd5, 32'd2);
      verify("s2b");
      check("s2b_nstall", 32'(stalls.size()), 32'd3);
      foreach (stalls[i]) check("s2b_hold", stalls[i], 32'h22);
      busy_mode = 0;

      // bus error on the third beat of an eight-beat burst
      fill(8);
      err_beat = 2;
      setup(32'h3000, 9'h010, 8, 7, 1'b0);
      wr(3'd5, 32'd2);
      wait_idle("err");
      rd(3'd5, r);
      check("err_status", r, 32'd2);
      @(negedge clock);
      check("err_ctl", bus_ctl(), 32'd0);
      check("err_addr", addressDataOut, 32'd0);
      check("err_ends", 32'(ends), 32'd1);
      check("err_nbursts", 32'(begins.size()), 32'd1);
      err_beat = -1;

      // zero-length start: accepted, clears error, no bus activity
      begins.delete();
      wr(3'd3, 32'd0);
      wr(3'd5, 32'd1);
      rd(3'd5, r);
      check("zero_status", r, 32'd0);
      repeat (5) @(negedge clock);
      check("zero_nbursts", 32'(begins.size()), 32'd0);
      check("zero_req", 32'(requestTransaction), 32'd0);

      // randomized transfers against the burst model
      busy_mode = 2;
      rd_gaps   = 1;
      for (int t = 0; t < 8; t++) begin
         int blk;
         blk         = $urandom_range(1, 20);
         grant_delay = $urandom_range(0, 3);
         fill(blk);
         setup($urandom, 9'($urandom), blk, $urandom_range(0, 7), 1'($urandom));
         wr(3'd5, cur_rnw ? 32'd1 : 32'd2);
         verify("rand");
      end
      busy_mode = 0;
      rd_gaps   = 0;

      // asynchronous reset while write beats are stalled on the bus
      fill(4);
      busy_mode = 3;
      setup(32'h4000, 9'h020, 4, 3, 1'b0);
      wr(3'd5, 32'd2);
      seen = 0;
      for (int i = 0; i < 200 && seen == 0; i++) begin
         @(negedge clock);
         if (dataValidOut) seen = 1;
      end
      check("ar_wdata_seen", 32'(seen), 32'd1);
      ends = 0;
      #2;
      reset = 1'b0;
      #1;
      check("ar_ctl", bus_ctl(), 32'd0);
      check("ar_addr", addressDataOut, 32'd0);
      check("ar_maddr", {23'd0, memAddress}, 32'd0);
      busy_mode = 0;
      repeat (2) @(negedge clock);
      check("ar_no_end", 32'(ends), 32'd0);
      reset = 1'b1;
      rd(3'd5, r);
      check("ar_status", r, 32'd0);
      rd(3'd1, r);
      check("ar_reg1", r, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
